// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
//   Shared definitions for the retirement-trace capture block:
//   - FSM state encodings (visible externally through o_state)
//   - capture mode constants
//   - entry layout {pc, inst} at the default 32/32 widths
// -----------------------------------------------------------------------------
package trace_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_POST    = 3'd2,
    ST_DONE    = 3'd3,
    ST_READ    = 3'd4
  } state_e;

  localparam logic MODE_LINEAR = 1'b0;  // stop when the buffer is full
  localparam logic MODE_CIRC   = 1'b1;  // wrap, overwriting oldest, until trigger

  localparam int TRACE_XLEN = 32;
  localparam int TRACE_IW   = 32;

  // Entry layout at the default widths; the top builds the same layout from
  // its own XLEN/IW parameters so non-default widths keep the field order.
  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_IW-1:0]   inst;
  } trace_entry_t;

endpackage : trace_pkg

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
//   Simple dual-port synchronous RAM: one write port, one registered read port.
//   Read-during-write to the same address returns the old contents.
//
//   Ports:
//     clk      in   clock
//     we_i     in   write enable
//     waddr_i  in   write address
//     wdata_i  in   write data
//     re_i     in   read enable; rdata_o updates on the same edge
//     raddr_i  in   read address
//     rdata_o  out  registered read data (holds when re_i is low)
// -----------------------------------------------------------------------------
module trace_ram #(
  parameter  int DEPTH = 512,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  // NOTE: the storage array and its read register have no reset on purpose so
  // they map onto RAM macros; the top only exposes rdata while it is valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : trace_ram

// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
//   Retirement-trace capture. Stores one {pc, inst} per retired instruction,
//   stops on a PC-match trigger plus a post-trigger count (or when a linear
//   capture fills), then reads the captured window out oldest-first.
//
//   Ports:
//     clk          in   system clock, rising edge
//     reset        in   asynchronous active-low reset
//     i_valid      in   retire strobe
//     i_pc/i_inst  in   retiring pc / instruction
//     i_arm        in   pulse: clear buffer and start a capture
//     i_mode       in   0 linear, 1 circular (latched on i_arm)
//     i_trig_en    in   trigger enable (latched on i_arm)
//     i_trig_pc    in   trigger pc (latched on i_arm)
//     i_post_cnt   in   entries stored after the trigger entry (latched on i_arm)
//     i_rd_req     in   read-next request
//     o_rd_valid   out  read data valid (one cycle after the accepted request)
//     o_rd_pc      out  read data pc (0 when not valid)
//     o_rd_inst    out  read data inst (0 when not valid)
//     o_rd_last    out  final entry of the window, qualifies o_rd_valid
//     o_state      out  FSM state encoding
//     o_count      out  entries held, saturating at DEPTH
//     o_triggered  out  trigger hit during this capture
//     o_wrapped    out  circular capture overwrote its oldest entry
// -----------------------------------------------------------------------------
module trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = TRACE_XLEN,
  parameter int IW    = TRACE_IW,
  parameter int DEPTH = 512,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic [IW-1:0]   i_inst,
  input  logic            i_arm,
  input  logic            i_mode,
  input  logic            i_trig_en,
  input  logic [XLEN-1:0] i_trig_pc,
  input  logic [CW-1:0]   i_post_cnt,
  input  logic            i_rd_req,
  output logic            o_rd_valid,
  output logic [XLEN-1:0] o_rd_pc,
  output logic [IW-1:0]   o_rd_inst,
  output logic            o_rd_last,
  output logic [2:0]      o_state,
  output logic [CW-1:0]   o_count,
  output logic            o_triggered,
  output logic            o_wrapped
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   inst;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            triggered_q, triggered_d;
  logic            wrapped_q, wrapped_d;
  logic [CW-1:0]   post_rem_q, post_rem_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   rd_rem_q, rd_rem_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;

  // Capture configuration, latched on i_arm
  logic            mode_q, mode_d;
  logic            trig_en_q, trig_en_d;
  logic [XLEN-1:0] trig_pc_q, trig_pc_d;
  logic [CW-1:0]   post_cnt_q, post_cnt_d;

  // RAM interface
  logic            ram_we;
  logic            ram_re;
  logic [AW-1:0]   ram_raddr;
  entry_t          ram_wdata;
  entry_t          ram_rdata;

  // ---------------------------------------------------------------------------
  // Decodes
  // ---------------------------------------------------------------------------
  logic          trig_hit;
  logic          count_full;
  logic          lin_full;
  logic [AW-1:0] oldest;

  assign trig_hit   = trig_en_q && (i_pc == trig_pc_q);
  assign count_full = (count_q == CW'(DEPTH));
  // The write about to happen brings a linear capture to DEPTH entries.
  assign lin_full   = (mode_q == MODE_LINEAR) && (count_q == CW'(DEPTH - 1));
  // Once wrapped, the write pointer sits on the oldest surviving entry.
  assign oldest     = wrapped_q ? wr_ptr_q : '0;

  assign ram_wdata.pc   = i_pc;
  assign ram_wdata.inst = i_inst;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets its default first so no path leaves a variable
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    triggered_d = triggered_q;
    wrapped_d   = wrapped_q;
    post_rem_d  = post_rem_q;
    rd_ptr_d    = rd_ptr_q;
    rd_rem_d    = rd_rem_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    mode_d      = mode_q;
    trig_en_d   = trig_en_q;
    trig_pc_d   = trig_pc_q;
    post_cnt_d  = post_cnt_q;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    ram_raddr   = rd_ptr_q;

    if (i_arm) begin
      // Arm from any state restarts capture; a coincident i_valid is dropped
      // and any read in flight is discarded (rd_valid_d stays 0).
      state_d     = ST_CAPTURE;
      wr_ptr_d    = '0;
      count_d     = '0;
      triggered_d = 1'b0;
      wrapped_d   = 1'b0;
      post_rem_d  = '0;
      rd_ptr_d    = '0;
      rd_rem_d    = '0;
      mode_d      = i_mode;
      trig_en_d   = i_trig_en;
      trig_pc_d   = i_trig_pc;
      post_cnt_d  = i_post_cnt;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end

        ST_CAPTURE, ST_POST: begin
          if (i_valid) begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (count_full) begin
              // Only reachable in circular mode: this write replaces the oldest.
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end

            if (state_q == ST_CAPTURE) begin
              if (trig_hit) begin
                triggered_d = 1'b1;
                post_rem_d  = post_cnt_q;
                state_d     = (post_cnt_q == '0 || lin_full) ? ST_DONE : ST_POST;
              end else if (lin_full) begin
                state_d = ST_DONE;
              end
            end else begin
              post_rem_d = post_rem_q - CW'(1);
              if (post_rem_q == CW'(1) || lin_full) begin
                state_d = ST_DONE;
              end
            end
          end
        end

        ST_DONE: begin
          rd_ptr_d  = oldest;
          rd_rem_d  = count_q;
          ram_raddr = oldest;
          if (i_rd_req && count_q != '0) begin
            ram_re     = 1'b1;
            rd_ptr_d   = oldest + AW'(1);
            rd_rem_d   = count_q - CW'(1);
            rd_valid_d = 1'b1;
            rd_last_d  = (count_q == CW'(1));
            state_d    = ST_READ;
          end
        end

        ST_READ: begin
          if (i_rd_req && rd_rem_q != '0) begin
            ram_re     = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_rem_d   = rd_rem_q - CW'(1);
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_rem_q == CW'(1));
          end else if (rd_valid_q && rd_last_q) begin
            // Final entry is on the outputs this cycle.
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      wrapped_q   <= 1'b0;
      post_rem_q  <= '0;
      rd_ptr_q    <= '0;
      rd_rem_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      mode_q      <= MODE_LINEAR;
      trig_en_q   <= 1'b0;
      trig_pc_q   <= '0;
      post_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      wrapped_q   <= wrapped_d;
      post_rem_q  <= post_rem_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_rem_q    <= rd_rem_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      mode_q      <= mode_d;
      trig_en_q   <= trig_en_d;
      trig_pc_q   <= trig_pc_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  trace_ram #(
    .DEPTH (DEPTH),
    .W     (XLEN + IW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The RAM read register is never reset, so read data is forced to zero
  // unless it is qualified by o_rd_valid.
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_last   = rd_valid_q & rd_last_q;
  assign o_rd_pc     = rd_valid_q ? ram_rdata.pc   : '0;
  assign o_rd_inst   = rd_valid_q ? ram_rdata.inst : '0;
  assign o_state     = state_q;
  assign o_count     = count_q;
  assign o_triggered = triggered_q;
  assign o_wrapped   = wrapped_q;

endmodule : trace_buffer

// File: tb/tb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer
//   Directed bench for trace_buffer at DEPTH=8.
// -----------------------------------------------------------------------------
module tb_trace_buffer;

  localparam int XLEN  = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            i_valid = 1'b0;
  logic [XLEN-1:0] i_pc = '0;
  logic [IW-1:0]   i_inst = '0;
  logic            i_arm = 1'b0;
  logic            i_mode = 1'b0;
  logic            i_trig_en = 1'b0;
  logic [XLEN-1:0] i_trig_pc = '0;
  logic [CW-1:0]   i_post_cnt = '0;
  logic            i_rd_req = 1'b0;
  logic            o_rd_valid;
  logic [XLEN-1:0] o_rd_pc;
  logic [IW-1:0]   o_rd_inst;
  logic            o_rd_last;
  logic [2:0]      o_state;
  logic [CW-1:0]   o_count;
  logic            o_triggered;
  logic            o_wrapped;

  int checks = 0;
  int errors = 0;

  // Collected read-out
  logic [XLEN-1:0] got_pc[$];
  logic [IW-1:0]   got_inst[$];
  logic            got_last[$];
  int              got_cyc[$];

  trace_buffer #(
    .XLEN  (XLEN),
    .IW    (IW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .i_pc        (i_pc),
    .i_inst      (i_inst),
    .i_arm       (i_arm),
    .i_mode      (i_mode),
    .i_trig_en   (i_trig_en),
    .i_trig_pc   (i_trig_pc),
    .i_post_cnt  (i_post_cnt),
    .i_rd_req    (i_rd_req),
    .o_rd_valid  (o_rd_valid),
    .o_rd_pc     (o_rd_pc),
    .o_rd_inst   (o_rd_inst),
    .o_rd_last   (o_rd_last),
    .o_state     (o_state),
    .o_count     (o_count),
    .o_triggered (o_triggered),
    .o_wrapped   (o_wrapped)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons)
  // ---------------------------------------------------------------------------
  function automatic logic [IW-1:0] inst_of(input logic [XLEN-1:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic mode, input logic ten, input logic [XLEN-1:0] tpc,
                     input logic [CW-1:0] post);
    i_arm      = 1'b1;
    i_mode     = mode;
    i_trig_en  = ten;
    i_trig_pc  = tpc;
    i_post_cnt = post;
    step();
    i_arm = 1'b0;
  endtask

  task automatic push(input logic [XLEN-1:0] pc);
    i_valid = 1'b1;
    i_pc    = pc;
    i_inst  = inst_of(pc);
    step();
    i_valid = 1'b0;
  endtask

  // Hold i_rd_req for n cycles, then idle a few more, logging every valid beat
  // together with the request cycle it was observed after.
  task automatic read_all(input int n);
    got_pc.delete();
    got_inst.delete();
    got_last.delete();
    got_cyc.delete();
    for (int c = 0; c < n + 3; c++) begin
      i_rd_req = (c < n);
      step();
      if (o_rd_valid) begin
        got_pc.push_back(o_rd_pc);
        got_inst.push_back(o_rd_inst);
        got_last.push_back(o_rd_last);
        got_cyc.push_back(c);
      end
    end
    i_rd_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", o_state); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
    checks++; if ({o_triggered, o_wrapped, o_rd_valid, o_rd_last} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {o_triggered, o_wrapped, o_rd_valid, o_rd_last});
    end
    checks++; if ({o_rd_pc, o_rd_inst} !== '0) begin errors++; $display("FAIL reset_rdata got %h want 0", {o_rd_pc, o_rd_inst}); end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL idle_after_reset got %0d want 0", o_state); end
  endtask

  task automatic test_linear_fill();
    arm(1'b0, 1'b0, '0, '0);
    checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL lin_armed_state got %0d want 1", o_state); end
    for (int k = 0; k < 10; k++) begin
      push(XLEN'(4 * k));
      if (k == 6) begin
        checks++; if (o_state !== 3'd1) begin errors++; $display("FAIL lin_state_7th got %0d want 1", o_state); end
      end
      if (k == 7) begin
        checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL lin_state_8th got %0d want 3", o_state); end
      end
    end
    checks++; if (o_count !== CW'(8)) begin errors++; $display("FAIL lin_count got %0d want 8", o_count); end
    checks++; if ({o_triggered, o_wrapped} !== 2'b00) begin errors++; $display("FAIL lin_flags got %b want 00", {o_triggered, o_wrapped}); end
  endtask

  // Follows test_linear_fill: 9 requests, 8 beats on consecutive cycles.
  task automatic test_read_throughput();
    read_all(9);
    checks++; if (got_pc.size() != 8) begin errors++; $display("FAIL thr_beats got %0d want 8", got_pc.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_pc[k] !== XLEN'(4 * k)) begin errors++; $display("FAIL thr_pc[%0d] got %h want %h", k, got_pc[k], 4 * k); end
      checks++; if (got_inst[k] !== inst_of(XLEN'(4 * k))) begin errors++; $display("FAIL thr_inst[%0d] got %h want %h", k, got_inst[k], inst_of(XLEN'(4 * k))); end
      checks++; if (got_last[k] !== (k == 7)) begin errors++; $display("FAIL thr_last[%0d] got %b want %b", k, got_last[k], (k == 7)); end
      checks++; if (got_cyc[k] != k) begin errors++; $display("FAIL thr_cycle[%0d] got %0d want %0d", k, got_cyc[k], k); end
    end
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL thr_end_state got %0d want 0", o_state); end
  endtask

  task automatic test_circular_trigger();
    arm(1'b1, 1'b1, 32'h30, CW'(2));
    for (int k = 0; k <= 16; k++) begin
      push(XLEN'(4 * k));
      if (k == 12 || k == 13) begin
        checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL circ_post_state[%0d] got %0d want 2", k, o_state); end
      end
      if (k == 14) begin
        checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL circ_done_state got %0d want 3", o_state); end
      end
    end
    checks++; if (o_count !== CW'(8)) begin errors++; $display("FAIL circ_count got %0d want 8", o_count); end
    checks++; if ({o_triggered, o_wrapped} !== 2'b11) begin errors++; $display("FAIL circ_flags got %b want 11", {o_triggered, o_wrapped}); end
    read_all(8);
    checks++; if (got_pc.size() != 8) begin errors++; $display("FAIL circ_beats got %0d want 8", got_pc.size()); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (got_pc[k] !== XLEN'(32'h1C + 4 * k)) begin errors++; $display("FAIL circ_pc[%0d] got %h want %h", k, got_pc[k], 32'h1C + 4 * k); end
      checks++; if (got_last[k] !== (k == 7)) begin errors++; $display("FAIL circ_last[%0d] got %b want %b", k, got_last[k], (k == 7)); end
    end
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL circ_end_state got %0d want 0", o_state); end
  endtask

  task automatic test_post_zero();
    arm(1'b1, 1'b1, 32'h08, '0);
    push(32'h00);
    push(32'h04);
    push(32'h08);
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL p0_state got %0d want 3", o_state); end
    push(32'h0C);
    checks++; if (o_count !== CW'(3)) begin errors++; $display("FAIL p0_count got %0d want 3", o_count); end
    checks++; if ({o_triggered, o_wrapped} !== 2'b10) begin errors++; $display("FAIL p0_flags got %b want 10", {o_triggered, o_wrapped}); end
    read_all(4);
    checks++; if (got_pc.size() != 3) begin errors++; $display("FAIL p0_beats got %0d want 3", got_pc.size()); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (got_pc[k] !== XLEN'(4 * k)) begin errors++; $display("FAIL p0_pc[%0d] got %h want %h", k, got_pc[k], 4 * k); end
      checks++; if (got_last[k] !== (k == 2)) begin errors++; $display("FAIL p0_last[%0d] got %b want %b", k, got_last[k], (k == 2)); end
    end
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL p0_end_state got %0d want 0", o_state); end
  endtask

  task automatic test_arm_collision();
    i_valid = 1'b1;
    i_pc    = 32'h100;
    i_inst  = inst_of(32'h100);
    arm(1'b1, 1'b1, 32'h104, '0);
    push(32'h104);
    checks++; if (o_state !== 3'd3) begin errors++; $display("FAIL coll_state got %0d want 3", o_state); end
    checks++; if (o_count !== CW'(1)) begin errors++; $display("FAIL coll_count got %0d want 1", o_count); end
    read_all(2);
    checks++; if (got_pc.size() != 1) begin errors++; $display("FAIL coll_beats got %0d want 1", got_pc.size()); end
    checks++; if (got_pc[0] !== 32'h104) begin errors++; $display("FAIL coll_pc got %h want 104", got_pc[0]); end
    checks++; if (got_last[0] !== 1'b1) begin errors++; $display("FAIL coll_last got %b want 1", got_last[0]); end
  endtask

  task automatic test_reset_mid_post();
    arm(1'b1, 1'b1, 32'h04, CW'(5));
    push(32'h00);
    push(32'h04);
    push(32'h08);
    checks++; if (o_state !== 3'd2) begin errors++; $display("FAIL rst_pre_state got %0d want 2", o_state); end
    checks++; if (o_count !== CW'(3)) begin errors++; $display("FAIL rst_pre_count got %0d want 3", o_count); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (o_state !== 3'd0) begin errors++; $display("FAIL rst_async_state got %0d want 0", o_state); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL rst_async_count got %0d want 0", o_count); end
    checks++; if (o_triggered !== 1'b0) begin errors++; $display("FAIL rst_async_trig got %b want 0", o_triggered); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    push(32'h0C);
    checks++; if (o_state !== 3'd0 || o_count !== '0) begin
      errors++; $display("FAIL rst_idle_ignores got state %0d count %0d want 0 0", o_state, o_count);
    end
  endtask

  initial begin
    test_reset();
    test_linear_fill();
    test_read_throughput();
    test_circular_trigger();
    test_post_zero();
    test_arm_collision();
    test_reset_mid_post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_trace_buffer

// File: doc/trace_buffer.md
# trace_buffer

Synthesizable retirement-trace capture block for the Yttrium SoC. It records one {pc, inst} entry per retired instruction into an on-chip RAM and stops on a programmable PC-match trigger after a post-trigger count. The captured window is then read out oldest-first through a request/valid port. It replaces per-cycle simulation dumping of pc/instr with hardware that sits beside core0 on the MotherBoard and works on silicon as well as in simulation.

## Interface
Parameters:
- XLEN, 32, pc width
- IW, 32, instruction width
- DEPTH, 512, entries; power of two, ≥ 4
- CW, $clog2(DEPTH+1), count width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- i_valid  in  1  retire strobe; sample i_pc/i_inst this cycle
- i_pc  in  XLEN  retiring pc
- i_inst  in  IW  retiring instruction
- i_arm  in  1  single-cycle pulse: clear buffer, start capture
- i_mode  in  1  0 = linear (stop when full), 1 = circular (wrap until trigger)
- i_trig_en  in  1  enable pc-match trigger
- i_trig_pc  in  XLEN  trigger pc
- i_post_cnt  in  CW  entries to store after the trigger entry; sampled on i_arm
- i_rd_req  in  1  read-next request
- o_rd_valid  out  1  o_rd_pc/o_rd_inst valid this cycle
- o_rd_pc  out  XLEN  read data, pc
- o_rd_inst  out  IW  read data, inst
- o_rd_last  out  1  qualifies o_rd_valid: final entry
- o_state  out  3  current FSM state
- o_count  out  CW  entries held (saturates at DEPTH)
- o_triggered  out  1  trigger occurred in this capture
- o_wrapped  out  1  circular mode overwrote oldest entry

## Operation
- States: IDLE=0, CAPTURE=1, POST=2, DONE=3, READ=4.
- IDLE: ignore i_valid. i_arm → CAPTURE; clear wr_ptr, count, o_triggered, o_wrapped; latch i_mode, i_post_cnt, i_trig_pc, i_trig_en.
- CAPTURE: each i_valid writes RAM[wr_ptr], wr_ptr+1 mod DEPTH, count+1 saturating at DEPTH.
  - Linear: write making count==DEPTH → DONE, no trigger needed.
  - Circular: write at count==DEPTH sets o_wrapped; oldest entry overwritten.
  - Trigger (i_trig_en latched, i_valid, i_pc==trig_pc): entry is stored, o_triggered=1; post_cnt==0 → DONE, else → POST with post_rem=post_cnt.
- POST: each i_valid stores, post_rem-1; reaching 0 → DONE. Linear mode filling → DONE early. No re-trigger.
- DONE: rd_ptr = oldest (wrapped ? wr_ptr : 0); rd_rem = count. i_rd_req with count>0 → READ. i_arm → fresh CAPTURE.
- READ: each accepted i_rd_req issues RAM read at rd_ptr, rd_ptr+1, rd_rem-1. o_rd_last marks rd_rem 1→0. After the last returned entry → IDLE. i_rd_req after the last is ignored.
- i_arm in any state except IDLE/DONE restarts capture (same clear as IDLE); in-flight read data is dropped.
- count==0 in DONE: i_rd_req ignored, state stays DONE.
- Pointers are $clog2(DEPTH) bits, natural wrap; no explicit compare against DEPTH.

## Timing
- Reset: state IDLE, all outputs 0, pointers/counters 0. RAM contents undefined, not cleared.
- Capture: write and state change on the same edge as the sampled i_valid. o_count/o_triggered update the next cycle.
- Read latency 1: i_rd_req at edge N → o_rd_valid high for one cycle after edge N+1. Back-to-back requests give one entry per cycle.
- i_arm and i_valid in the same cycle: arm wins; that sample is not stored.
- Trigger and linear-full on the same write → DONE, o_triggered=1.
- Reset deasserted asynchronously is the integrator's problem; the block requires synchronised deassertion.

## Structure
- trace_pkg: state encodings, MODE_LINEAR/MODE_CIRC constants, entry struct {pc, inst}.
- Sub-module trace_ram: simple dual-port sync RAM, DEPTH × (XLEN+IW), 1 write + 1 registered read port, no reset.
- Top holds FSM, pointers, counters, trigger compare.

## Test plan
All scenarios use DEPTH=8.
- Linear fill: arm mode 0, 10 valids pc=0x00,0x04,…,0x24 → DONE after 8th, count=8, readout pc 0x00..0x1C, o_rd_last on 0x1C, then IDLE.
- Circular trigger: arm mode 1, trig_pc=0x30, post=2, pcs 0x00..0x40 step 4 → DONE after pc 0x38, o_wrapped=1, readout 0x1C..0x38 (8 entries).
- Post=0: trigger on 0x08 in mode 1 → DONE same edge, count=3, readout 0x00,0x04,0x08.
- Arm collision: i_arm with i_valid pc=0x100, then valid pc=0x104 → first entry read is 0x104.
- Read throughput: after linear fill hold i_rd_req 8 cycles → o_rd_valid 8 consecutive cycles at one-cycle lag. A 9th request is ignored.
- Reset mid-POST: reset=0 for one cycle → o_state=0, o_count=0, o_triggered=0 immediately, before the next clock edge.
